uart_rx_fsm: RTL

- Frame controller for the UART receiver.
- Detects the start bit, runs the per-bit oversampling edge counter, and enables and consumes the majority-vote data sampler.
- Sequences start, data, parity and stop bits, deserializes data LSB first, checks parity and stop, and flags the outcome of each frame.
- Sits between the RX pin and the RX output register. The data sampler is driven from its edge_count / data_sample_en outputs.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_edge_bit_counter.sv | 39 +++
 rtl/uart_rx_fsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame controller.
// Break detection is added to uart_rx_fsm when UART_RX_BREAK_DET_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic prescale_legal(input int prescale);
        return (prescale == PRESCALE_8) || (prescale == PRESCALE_16) ||
               (prescale == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter for one UART frame.
// Held at zero while disabled; strobes mark the last edge and the sampling edge of each bit.
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  wrap,
    output logic                  decision
);

    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] decision_edge;

    assign last_edge     = prescale - PRESCALE_W'(1);
    assign decision_edge = prescale - PRESCALE_W'(2);

    // Strobes are not gated by enable so the FSM can use them to derive enable itself.
    assign wrap     = (edge_count == last_edge);
    assign decision = (edge_count == decision_edge);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            edge_count <= '0;
            bit_cnt    <= '0;
        end else if (wrap) begin
            edge_count <= '0;
            bit_cnt    <= bit_cnt + BIT_W'(1);
        end else begin
            edge_count <= edge_count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, deserialization, parity/stop checks.
// Define UART_RX_BREAK_DET_EN to generate the break_det pulse; otherwise it is tied low.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic                  data_sample_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  break_det
);

    // state  | meaning
    // IDLE   | line idle, waiting for a low RX_IN with a legal Prescale
    // START  | start bit; rejected as a glitch if it samples high
    // DATA   | DATA_WIDTH data bits, LSB first
    // PARITY | optional parity bit
    // STOP   | stop bit; frame outcome pulses are issued here

    localparam int BIT_W = $clog2(DATA_WIDTH + 3);

    state_t                state;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_mis;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      data_idx;
    logic                  wrap;
    logic                  decision;
    logic                  glitch_now;
    logic                  run;
    logic                  par_exp;

    // A rejected start drops enable on the same edge so the counter is already clear in IDLE.
    assign glitch_now = (state == START) && decision && sampled_bit;
    assign run        = (state != IDLE) && !glitch_now;
    assign data_idx   = bit_cnt - BIT_W'(1);
    assign par_exp    = (par_typ_q == PAR_ODD) ? ~^P_DATA : ^P_DATA;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .enable     (run),
        .prescale   (prescale_q),
        .edge_count (edge_count),
        .bit_cnt    (bit_cnt),
        .wrap       (wrap),
        .decision   (decision)
    );

`ifdef UART_RX_BREAK_DET_EN
    logic break_q;
    assign break_det = break_q;
`else
    assign break_det = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            prescale_q     <= PRESCALE_W'(PRESCALE_8);
            par_en_q       <= 1'b0;
            par_typ_q      <= PAR_EVEN;
            par_mis        <= 1'b0;
            data_sample_en <= 1'b0;
            P_DATA         <= '0;
            data_valid     <= 1'b0;
            par_err        <= 1'b0;
            stp_err        <= 1'b0;
            strt_glitch    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_q        <= 1'b0;
`endif
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!RX_IN && prescale_legal(int'(Prescale))) begin
                        state          <= START;
                        prescale_q     <= Prescale;
                        par_en_q       <= PAR_EN;
                        par_typ_q      <= PAR_TYP;
                        par_mis        <= 1'b0;
                        data_sample_en <= 1'b1;
                    end
                end
                START: begin
                    if (glitch_now) begin
                        strt_glitch    <= 1'b1;
                        state          <= IDLE;
                        data_sample_en <= 1'b0;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (decision) begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (data_idx == BIT_W'(i)) begin
                                P_DATA[i] <= sampled_bit;
                            end
                        end
                    end
                    if (wrap && (bit_cnt == BIT_W'(DATA_WIDTH))) begin
                        state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decision) begin
                        par_mis <= (sampled_bit != par_exp);
                    end
                    if (wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Registered at the sampling edge so the pulses land on the wrap cycle.
                    if (decision) begin
                        par_err    <= par_mis;
                        stp_err    <= !sampled_bit;
                        data_valid <= !par_mis && sampled_bit;
`ifdef UART_RX_BREAK_DET_EN
                        break_q    <= !sampled_bit && (P_DATA == '0);
`endif
                    end
                    if (wrap) begin
                        state          <= IDLE;
                        data_sample_en <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    data_sample_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
